// File: rtl/shift_reg_sequencer_pkg.sv
// rtl/shift_reg_sequencer_pkg.sv - op/select encodings and FSM state type for the shift register sequencer
// Optional rotate support is selected with SHIFT_SEQ_ROTATE_EN.
package shift_reg_sequencer_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHR   = 2'b01;
   localparam logic [1:0] OP_SHL   = 2'b10;
   localparam logic [1:0] OP_ROT   = 2'b11;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Mode select presented to the register while a command is running.
   function automatic logic [1:0] op_to_sel(input logic [1:0] op);
      logic [1:0] sel;
      sel = SEL_HOLD;
      case (op)
         OP_LOAD: sel = SEL_LOAD;
         OP_SHR:  sel = SEL_SHR;
         OP_SHL:  sel = SEL_SHL;
`ifdef SHIFT_SEQ_ROTATE_EN
         OP_ROT:  sel = SEL_SHR;
`else
         OP_ROT:  sel = SEL_HOLD;
`endif
         default: sel = SEL_HOLD;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/shift_step_counter.sv
// rtl/shift_step_counter.sv - loadable down counter tracking remaining shift steps
// last_o flags the final step (count == 1).
module shift_step_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign last_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - command sequencer driving a universal shift register's mode/data pins
// Define SHIFT_SEQ_ROTATE_EN to make op 11 rotate right; otherwise op 11 runs hold cycles.
module shift_reg_sequencer
   import shift_reg_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_serial,
   input  logic [WIDTH-1:0] A_par,
   output logic             s1,
   output logic             s0,
   output logic [WIDTH-1:0] I_par,
   output logic             MSB_in,
   output logic             LSB_in,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             serial_q, serial_d;

   logic             accept;
   logic             ctr_load;
   logic [CNT_W-1:0] ctr_val;
   logic             ctr_dec;
   logic [CNT_W-1:0] ctr_count;
   logic             ctr_last;
   logic             unused_fb;

   assign accept = cmd_valid && (state_q == IDLE);

   shift_step_counter #(
      .CNT_W (CNT_W)
   ) u_step_counter (
      .clk_i      (CLK),
      .rst_i      (Clear),
      .load_i     (ctr_load),
      .load_val_i (ctr_val),
      .dec_i      (ctr_dec),
      .count_o    (ctr_count),
      .last_o     (ctr_last)
   );

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state_q  <= IDLE;
         op_q     <= OP_LOAD;
         data_q   <= '0;
         serial_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         serial_q <= serial_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      serial_d = serial_q;
      ctr_load = 1'b0;
      ctr_val  = '0;
      ctr_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d     = cmd_op;
               data_d   = cmd_data;
               serial_d = cmd_serial;
               if (cmd_op == OP_LOAD) begin
                  ctr_load = 1'b1;
                  ctr_val  = CNT_W'(1);
                  state_d  = RUN;
               end else if (cmd_count != '0) begin
                  ctr_load = 1'b1;
                  ctr_val  = cmd_count;
                  state_d  = RUN;
               end else begin
                  // Zero-length shift: report completion without touching the register.
                  state_d  = DONE;
               end
            end
         end
         RUN: begin
            ctr_dec = 1'b1;
            if (ctr_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      {s1, s0}  = SEL_HOLD;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         RUN: begin
            busy     = 1'b1;
            {s1, s0} = op_to_sel(op_q);
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   always_comb begin
      I_par  = (op_q == OP_LOAD) ? data_q : '0;
      MSB_in = (op_q == OP_SHR) ? serial_q : 1'b0;
      LSB_in = (op_q == OP_SHL) ? serial_q : 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      // Rotate recirculates the register's bit 0 straight back into the MSB.
      if (op_q == OP_ROT) begin
         MSB_in = A_par[0];
      end
`endif
   end

   assign unused_fb = ^{A_par, ctr_count};

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb/tb_shift_reg_sequencer.sv - scoreboard bench for shift_reg_sequencer with a behavioural shift register
module tb_shift_reg_sequencer;

   logic       CLK = 1'b0;
   logic       Clear = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_data = 4'h0;
   logic [2:0] cmd_count = 3'd0;
   logic       cmd_serial = 1'b0;
   logic [3:0] A_par;
   logic       s1, s0;
   logic [3:0] I_par;
   logic       MSB_in, LSB_in;
   logic       busy, done;

   shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .CLK        (CLK),
      .Clear      (Clear),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .cmd_serial (cmd_serial),
      .A_par      (A_par),
      .s1         (s1),
      .s0         (s0),
      .I_par      (I_par),
      .MSB_in     (MSB_in),
      .LSB_in     (LSB_in),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLK = ~CLK;

   // Downstream universal shift register, driven only by the DUT's pins.
   logic [3:0] sr = 4'b0000;
   assign A_par = sr;
   always @(posedge CLK) begin
      case ({s1, s0})
         2'b01:   sr <= {MSB_in, sr[3:1]};
         2'b10:   sr <= {sr[2:0], LSB_in};
         2'b11:   sr <= I_par;
         default: sr <= sr;
      endcase
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] val;
      int         n;
      int         acc;
   } exp_t;
   exp_t sb[$];

   logic [3:0] mreg = 4'b0000;
   int last_acc = 0;
   int last_n = 0;
   bit chain = 0;
   int pushed = 0;
   int dones = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Register contents after applying a command, from the op's meaning alone.
   function automatic logic [3:0] model(input logic [3:0] v, input logic [1:0] op,
                                        input logic [3:0] d, input int c, input logic s);
      logic [3:0] r;
      r = v;
      if (op == 2'b00) return d;
      for (int i = 0; i < c; i++) begin
         case (op)
            2'b01: r = (r >> 1) | {s, 3'b000};
            2'b10: r = (r << 1) | {3'b000, s};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: r = (r >> 1) | {r[0], 3'b000};
`else
            2'b11: r = r;
`endif
            default: r = r;
         endcase
      end
      return r;
   endfunction

   int busy_run = 0;
   always @(negedge CLK) begin
      if (Clear) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            dones++;
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("final_value", int'(sr), int'(e.val));
               check("done_latency", cyc - e.acc, e.n);
               check("busy_cycles", busy_run, e.n + 1);
               check("sel_hold_in_done", int'({s1, s0}), 0);
            end
            busy_run = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c,
                        input logic s, input bit expect_done);
      int n;
      int w;
      int acc;
      @(negedge CLK);
      cmd_op = op; cmd_data = d; cmd_count = c; cmd_serial = s;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge CLK);
         w++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         chain = 0;
         return;
      end
      acc = cyc + 1;
      n = (op == 2'b00) ? 1 : int'(c);
      if (chain) check("accept_gap", acc - last_acc, last_n + 2);
      @(posedge CLK);
      if (expect_done) begin
         mreg = model(mreg, op, d, n, s);
         sb.push_back('{val: mreg, n: n, acc: acc});
         pushed++;
      end
      last_acc = acc;
      last_n = n;
      chain = 1;
      #1 cmd_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge CLK);
      chain = 0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge CLK);
         w++;
      end
      check("scoreboard_drained", sb.size(), 0);
      chain = 0;
   endtask

   initial begin
      #1;
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_sel", int'({s1, s0}), 0);
      check("rst_I_par", int'(I_par), 0);
      check("rst_serial", int'({MSB_in, LSB_in}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge CLK);
      Clear = 1'b0;
      idle(1);

      issue(2'b00, 4'b1010, 3'd5, 1'b1, 1);
      issue(2'b01, 4'b0000, 3'd2, 1'b1, 1);
      issue(2'b00, 4'b0011, 3'd0, 1'b0, 1);
      issue(2'b10, 4'b1111, 3'd3, 1'b0, 1);
      issue(2'b00, 4'b0110, 3'd0, 1'b0, 1);
      issue(2'b01, 4'b0000, 3'd0, 1'b1, 1);
      issue(2'b00, 4'b0001, 3'd0, 1'b0, 1);
      issue(2'b11, 4'b0000, 3'd1, 1'b0, 1);
      issue(2'b11, 4'b0000, 3'd7, 1'b1, 1);
      drain();

      // Abort a right shift with three steps still to go.
      issue(2'b00, 4'b0110, 3'd0, 1'b0, 1);
      drain();
      issue(2'b01, 4'b0000, 3'd5, 1'b1, 0);
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      Clear = 1'b1;
      #1;
      check("abort_sel", int'({s1, s0}), 0);
      check("abort_I_par", int'(I_par), 0);
      check("abort_serial", int'({MSB_in, LSB_in}), 0);
      check("abort_busy_done", int'({busy, done}), 0);
      check("abort_cmd_ready", int'(cmd_ready), 1);
      mreg = model(mreg, 2'b01, 4'b0000, 2, 1'b1);
      repeat (3) @(negedge CLK);
      Clear = 1'b0;
      repeat (2) @(negedge CLK);
      check("abort_reg_holds", int'(sr), int'(mreg));
      chain = 0;

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
      check("done_pulse_count", dones, pushed);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
